// File: rtl/nn_sld_feeder.sv
// rtl/nn_sld_feeder.sv - column feeder for the 6x6 sliding-window register file
// Streams stride-aligned column batches from the image buffer and hands complete windows to the PE array.
module nn_sld_feeder #(
    parameter int DATA_WIDTH       = 8,
    parameter int ROW_NUM          = 6,
    parameter int ADDR_WIDTH       = 10,
    parameter int CNT_WIDTH        = 8,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * ROW_NUM
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH-1:0]       i_base_addr,
    input  logic [CNT_WIDTH-1:0]        i_num_cols,
    input  logic [1:0]                  i_mode,
    input  logic                        i_3x3,
    input  logic [1:0]                  i_stride,
    output logic                        o_mem_en,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_mem_data,
    output logic [TOTAL_DATA_WIDTH-1:0] o_data,
    output logic                        o_shift,
    output logic [1:0]                  o_mode,
    output logic                        o_3x3,
    output logic                        o_win_valid,
    input  logic                        i_win_ack,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [CNT_WIDTH-1:0]        ncols_q, ncols_d;
    logic [CNT_WIDTH-1:0]        cols_q, cols_d;
    logic [1:0]                  mode_q, mode_d;
    logic                        m3_q, m3_d;
    logic [1:0]                  stride_q, stride_d;
    logic [2:0]                  batch_q, batch_d;
    logic                        win_q, win_d;
    logic                        rd_p1_q, last_p1_q;
    logic                        shift_q, last_shift_q;
    logic [TOTAL_DATA_WIDTH-1:0] data_q;

    logic                        rd_en;
    logic                        rd_last;
    logic [CNT_WIDTH-1:0]        k_in;
    logic [CNT_WIDTH:0]          stride_ext;
    logic                        next_fits;

    assign k_in       = (i_mode == 2'b00) ? CNT_WIDTH'(3) : CNT_WIDTH'(6);
    assign stride_ext = {{(CNT_WIDTH-1){1'b0}}, stride_q};
    assign next_fits  = ({1'b0, cols_q} + stride_ext) <= {1'b0, ncols_q};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ncols_d  = ncols_q;
        cols_d   = cols_q;
        mode_d   = mode_q;
        m3_d     = m3_q;
        stride_d = stride_q;
        batch_d  = batch_q;
        win_d    = win_q;
        rd_en    = 1'b0;
        rd_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d   = i_base_addr;
                    ncols_d  = i_num_cols;
                    mode_d   = i_mode;
                    m3_d     = i_3x3;
                    stride_d = (i_stride == 2'd0) ? 2'd1 : i_stride;
                    cols_d   = '0;
                    batch_d  = k_in[2:0];
                    state_d  = (i_num_cols < k_in) ? S_DONE : S_FILL;
                end
            end
            S_FILL, S_STEP: begin
                rd_en   = 1'b1;
                addr_d  = addr_q + 1'b1;
                cols_d  = (cols_q == ncols_q) ? cols_q : cols_q + 1'b1;
                batch_d = batch_q - 3'd1;
                if (batch_q == 3'd1) begin
                    rd_last = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Ack only counts once the last shift of the batch has landed.
                if (win_q && i_win_ack) begin
                    win_d = 1'b0;
                    if (next_fits) begin
                        state_d = S_STEP;
                        batch_d = {1'b0, stride_q};
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (shift_q && last_shift_q) begin
            win_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            ncols_q      <= '0;
            cols_q       <= '0;
            mode_q       <= '0;
            m3_q         <= 1'b0;
            stride_q     <= '0;
            batch_q      <= '0;
            win_q        <= 1'b0;
            rd_p1_q      <= 1'b0;
            last_p1_q    <= 1'b0;
            shift_q      <= 1'b0;
            last_shift_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ncols_q      <= ncols_d;
            cols_q       <= cols_d;
            mode_q       <= mode_d;
            m3_q         <= m3_d;
            stride_q     <= stride_d;
            batch_q      <= batch_d;
            win_q        <= win_d;
            // Read at t, buffer data at t+1, registered column with shift at t+2.
            rd_p1_q      <= rd_en;
            last_p1_q    <= rd_last;
            shift_q      <= rd_p1_q;
            last_shift_q <= last_p1_q;
            if (rd_p1_q) begin
                data_q <= i_mem_data;
            end
        end
    end

    assign o_mem_en    = rd_en;
    assign o_mem_addr  = addr_q;
    assign o_data      = data_q;
    assign o_shift     = shift_q;
    assign o_mode      = mode_q;
    assign o_3x3       = m3_q;
    assign o_win_valid = win_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_nn_sld_feeder.sv
// tb/tb_nn_sld_feeder.sv - self-checking bench for nn_sld_feeder
module tb_nn_sld_feeder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_base_addr = '0;
    logic [7:0]  i_num_cols = '0;
    logic [1:0]  i_mode = '0;
    logic        i_3x3 = 1'b0;
    logic [1:0]  i_stride = '0;
    logic        i_win_ack = 1'b0;
    logic        o_mem_en;
    logic [9:0]  o_mem_addr;
    logic [47:0] mem_data = '0;
    logic [47:0] o_data;
    logic        o_shift;
    logic [1:0]  o_mode;
    logic        o_3x3;
    logic        o_win_valid;
    logic        o_busy;
    logic        o_done;

    nn_sld_feeder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_cols(i_num_cols), .i_mode(i_mode), .i_3x3(i_3x3), .i_stride(i_stride),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
        .o_data(o_data), .o_shift(o_shift), .o_mode(o_mode), .o_3x3(o_3x3),
        .o_win_valid(o_win_valid), .i_win_ack(i_win_ack), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [47:0] pat(input logic [9:0] a);
        return {8'hA5 ^ a[7:0], 6'd0, a, 8'h3C, a[7:0], ~a[7:0]};
    endfunction

    // Image buffer: one-cycle read latency, junk when not enabled.
    always @(posedge i_clk) mem_data <= o_mem_en ? pat(o_mem_addr) : 48'hDEAD_BEEF_0BAD;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [9:0]  exp_addr[$];
    logic [47:0] exp_data[$];
    int          exp_shift_cyc[$];
    int          exp_win[$];
    int          rd_cnt = 0;
    int          sh_cnt = 0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            if (o_mem_en) begin
                rd_cnt++;
                exp_shift_cyc.push_back(cyc + 2);
                if (exp_addr.size() == 0) chk("unexpected_read", {54'd0, o_mem_addr}, 64'hFFFF);
                else chk("rd_addr", {54'd0, o_mem_addr}, {54'd0, exp_addr.pop_front()});
            end
            if (o_shift) begin
                sh_cnt++;
                if (exp_data.size() == 0 || exp_shift_cyc.size() == 0) begin
                    chk("unexpected_shift", {16'd0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("shift_latency", cyc, exp_shift_cyc.pop_front());
                    chk("shift_data", {16'd0, o_data}, {16'd0, exp_data.pop_front()});
                end
            end
        end
    end

    task automatic setup_model(input logic [9:0] base, input logic [7:0] n,
                               input logic [1:0] mode, input logic [1:0] s, output int k);
        int se, wins, reads;
        logic [9:0] a;
        k = (mode == 2'b00) ? 3 : 6;
        se = (s == 2'd0) ? 1 : int'(s);
        wins = (int'(n) < k) ? 0 : (int'(n) - k) / se + 1;
        reads = (wins == 0) ? 0 : k + (wins - 1) * se;
        exp_addr.delete(); exp_data.delete(); exp_shift_cyc.delete(); exp_win.delete();
        for (int i = 0; i < reads; i++) begin
            a = base + i[9:0];
            exp_addr.push_back(a);
            exp_data.push_back(pat(a));
        end
        for (int j = 0; j < wins; j++) exp_win.push_back(k + j * se);
        rd_cnt = 0;
        sh_cnt = 0;
    endtask

    task automatic run_frame(input logic [9:0] base, input logic [7:0] n, input logic [1:0] mode,
                             input logic [1:0] s, input logic m3, input int hold, input bit noise,
                             input int exp_reads, input int exp_wins);
        int k, c0, guard, wins_seen;
        bit done_seen;
        logic [47:0] held;
        setup_model(base, n, mode, s, k);
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = base; i_num_cols = n; i_mode = mode; i_3x3 = m3; i_stride = s;
        @(negedge i_clk);
        i_start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", {63'd0, o_busy}, 64'd1);
        chk("mode_latched", {62'd0, o_mode}, {62'd0, mode});
        chk("3x3_latched", {63'd0, o_3x3}, {63'd0, m3});
        if (noise) begin
            i_start = 1'b1; i_base_addr = 10'h3FF; i_num_cols = 8'd3; i_mode = 2'b00; i_win_ack = 1'b1;
        end
        guard = 0; wins_seen = 0; done_seen = 0;
        while (!done_seen && guard < 400) begin
            if (o_win_valid) begin
                if (wins_seen == 0) chk("first_valid_latency", cyc - c0, k + 2);
                chk("window_after_shifts", sh_cnt, (exp_win.size() > 0) ? exp_win.pop_front() : -1);
                wins_seen++;
                held = o_data;
                for (int h = 0; h < hold; h++) begin
                    @(negedge i_clk); guard++;
                    chk("hold_valid", {63'd0, o_win_valid}, 64'd1);
                    chk("hold_no_read", {63'd0, o_mem_en}, 64'd0);
                    chk("hold_no_shift", {63'd0, o_shift}, 64'd0);
                    chk("hold_data", {16'd0, o_data}, {16'd0, held});
                end
                i_win_ack = 1'b1;
                @(negedge i_clk); guard++;
                i_win_ack = 1'b0;
                chk("valid_drop_after_ack", {63'd0, o_win_valid}, 64'd0);
            end
            if (o_done) begin
                done_seen = 1;
            end else begin
                @(negedge i_clk); guard++;
                i_start = 1'b0; i_win_ack = 1'b0;
            end
        end
        if (!done_seen) begin
            chk("frame_timeout", 64'd0, 64'd1);
        end else begin
            if (exp_reads == 0) chk("done_latency_no_reads", cyc - c0, 0);
            chk("windows", wins_seen, exp_wins);
            chk("reads", rd_cnt, exp_reads);
            chk("shifts", sh_cnt, exp_reads);
            chk("reads_missing", exp_addr.size(), 0);
            @(negedge i_clk);
            i_start = 1'b0; i_win_ack = 1'b0;
            chk("done_one_cycle", {63'd0, o_done}, 64'd0);
            chk("idle_after_done", {63'd0, o_busy}, 64'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, {63'd0, o_mem_en}, 64'd0);
        chk({tag, "_mem_addr"}, {54'd0, o_mem_addr}, 64'd0);
        chk({tag, "_data"}, {16'd0, o_data}, 64'd0);
        chk({tag, "_shift"}, {63'd0, o_shift}, 64'd0);
        chk({tag, "_mode"}, {62'd0, o_mode}, 64'd0);
        chk({tag, "_3x3"}, {63'd0, o_3x3}, 64'd0);
        chk({tag, "_win_valid"}, {63'd0, o_win_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
    endtask

    typedef struct {
        logic [9:0] base;
        logic [7:0] n;
        logic [1:0] mode;
        logic [1:0] s;
        logic       m3;
        int         hold;
        bit         noise;
        int         reads;
        int         wins;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int k;
        tbl[0] = '{10'h010, 8'd6,  2'b01, 2'd1, 1'b0, 0,  1'b0, 6,  1};
        tbl[1] = '{10'h020, 8'd8,  2'b00, 2'd2, 1'b1, 2,  1'b0, 7,  3};
        tbl[2] = '{10'h030, 8'd7,  2'b10, 2'd2, 1'b0, 10, 1'b0, 6,  1};
        tbl[3] = '{10'h3FE, 8'd5,  2'b00, 2'd0, 1'b1, 0,  1'b0, 5,  3};
        tbl[4] = '{10'h040, 8'd12, 2'b11, 2'd3, 1'b1, 1,  1'b1, 12, 3};
        tbl[5] = '{10'h050, 8'd2,  2'b00, 2'd1, 1'b0, 0,  1'b1, 0,  0};
        tbl[6] = '{10'h060, 8'd5,  2'b01, 2'd1, 1'b1, 0,  1'b0, 0,  0};
        tbl[7] = '{10'h070, 8'd3,  2'b00, 2'd3, 1'b0, 0,  1'b0, 3,  1};

        repeat (2) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_frame(tbl[v].base, tbl[v].n, tbl[v].mode, tbl[v].s, tbl[v].m3,
                      tbl[v].hold, tbl[v].noise, tbl[v].reads, tbl[v].wins);
        end

        // Abort mid-FILL, then the same frame must replay cleanly.
        setup_model(10'h010, 8'd6, 2'b01, 2'd1, k);
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = 10'h010; i_num_cols = 8'd6; i_mode = 2'b01; i_3x3 = 1'b1; i_stride = 2'd1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("abort_in_fill", {63'd0, o_mem_en}, 64'd1);
        #1 i_rst = 1'b0;
        #1 chk_all_zero("async_abort");
        repeat (2) @(negedge i_clk);
        chk("abort_no_done", {63'd0, o_done}, 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_all_zero("after_abort");
        run_frame(10'h010, 8'd6, 2'b01, 2'd1, 1'b0, 0, 1'b0, 6, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_fail);
        $fatal(1);
    end

endmodule
